// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-cold column drive, row synchronizer, press/release
// debounce and a small key-code FIFO with a sticky overflow flag.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV   = 1000,
   parameter int DEB_CNT    = 50000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow,
   input  logic       overflow_clr
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CNT - 1);
   localparam logic [AW:0]   FIFO_FULL  = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

   state_t          state_reg;
   logic [1:0]      idx_reg;
   logic [3:0]      col_reg;
   logic [DW-1:0]   dwell_reg;
   logic [CW-1:0]   deb_reg;
   logic [3:0]      pat_reg;
   logic [3:0]      row_meta_reg;
   logic [3:0]      row_sync_reg;

   logic [3:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     count_reg;
   logic            overflow_reg;

   logic [3:0]      rs;
   logic [1:0]      idx_inc;
   logic            pat_match;
   logic            push;
   logic [3:0]      push_code;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop;
   logic            accept;
   logic            drop;

   function automatic logic single_zero(input logic [3:0] v);
      logic [3:0] z;
      z = ~v;
      return (z != 4'd0) && ((z & (z - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] zero_pos(input logic [3:0] v);
      logic [1:0] p;
      p = 2'd3;
      if (!v[0])      p = 2'd0;
      else if (!v[1]) p = 2'd1;
      else if (!v[2]) p = 2'd2;
      return p;
   endfunction

   function automatic logic [3:0] col_of(input logic [1:0] i);
      return ~(4'b0001 << i);
   endfunction

   // Rows come straight from the keypad contacts; two flops before any use.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row_meta_reg <= 4'hF;
         row_sync_reg <= 4'hF;
      end else begin
         row_meta_reg <= row;
         row_sync_reg <= row_meta_reg;
      end
   end

   assign rs        = row_sync_reg;
   assign idx_inc   = idx_reg + 2'd1;
   assign pat_match = (rs == pat_reg);
   assign push      = (state_reg == DEBOUNCE) && pat_match && (deb_reg == DEB_LAST);
   assign push_code = {zero_pos(pat_reg), idx_reg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= SCAN;
         idx_reg   <= 2'd0;
         col_reg   <= 4'hE;
         dwell_reg <= '0;
         deb_reg   <= '0;
         pat_reg   <= 4'hF;
      end else begin
         case (state_reg)
            SCAN: begin
               if (dwell_reg == DWELL_LAST) begin
                  dwell_reg <= '0;
                  if (single_zero(rs)) begin
                     pat_reg   <= rs;
                     deb_reg   <= '0;
                     state_reg <= DEBOUNCE;
                  end else begin
                     // Idle rows and ghost/multi-key patterns both just move on.
                     idx_reg <= idx_inc;
                     col_reg <= col_of(idx_inc);
                  end
               end else begin
                  dwell_reg <= dwell_reg + 1'b1;
               end
            end
            DEBOUNCE: begin
               if (pat_match) begin
                  if (deb_reg == DEB_LAST) begin
                     deb_reg   <= '0;
                     state_reg <= HELD;
                  end else begin
                     deb_reg <= deb_reg + 1'b1;
                  end
               end else begin
                  state_reg <= SCAN;
                  dwell_reg <= '0;
                  idx_reg   <= idx_inc;
                  col_reg   <= col_of(idx_inc);
               end
            end
            HELD: begin
               if (rs == 4'hF) begin
                  if (deb_reg == DEB_LAST) begin
                     deb_reg   <= '0;
                     dwell_reg <= '0;
                     state_reg <= SCAN;
                     idx_reg   <= idx_inc;
                     col_reg   <= col_of(idx_inc);
                  end else begin
                     deb_reg <= deb_reg + 1'b1;
                  end
               end else begin
                  deb_reg <= '0;
               end
            end
            default: begin
               state_reg <= SCAN;
               dwell_reg <= '0;
               deb_reg   <= '0;
            end
         endcase
      end
   end

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == FIFO_FULL);
   assign pop        = !fifo_empty && key_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign accept     = push && (!fifo_full || pop);
   assign drop       = push && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (accept) mem[wr_ptr_reg] <= push_code;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({accept, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (drop)              overflow_reg <= 1'b1;
         else if (overflow_clr) overflow_reg <= 1'b0;
      end
   end

   assign col       = col_reg;
   assign key_valid = !fifo_empty;
   assign key_code  = fifo_empty ? 4'h0 : mem[rd_ptr_reg];
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized and directed bench for keypad_scan_ctrl against a queue-based behavioural model.
module tb_keypad_scan_ctrl;
   localparam int SD = 4;
   localparam int DC = 8;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row = 4'hF;
   logic       key_ready = 1'b0;
   logic       overflow_clr = 1'b0;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       overflow;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b1;

   // Model: mode 0 scanning, 1 confirming a press, 2 waiting for release.
   int         m_mode, m_col, m_dwell, m_run;
   logic [3:0] m_pat, m_meta, m_rs;
   logic [3:0] m_fifo [$];
   bit         m_ovf;

   always #5 clk = ~clk;

   keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_CNT(DC), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
      .key_valid(key_valid), .key_ready(key_ready), .overflow(overflow),
      .overflow_clr(overflow_clr)
   );

   function automatic int zeros(input logic [3:0] v);
      int n = 0;
      for (int i = 0; i < 4; i++) if (!v[i]) n++;
      return n;
   endfunction

   function automatic int zero_row(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (!v[i]) return i;
      return 0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_col = 0; m_dwell = 0; m_run = 0;
      m_pat = 4'hF; m_meta = 4'hF; m_rs = 4'hF;
      m_fifo.delete();
      m_ovf = 1'b0;
   endtask

   task automatic model_step();
      bit do_push, drop, pop;
      logic [3:0] code;
      do_push = 0; drop = 0; code = 4'h0;
      pop = (m_fifo.size() != 0) && key_ready;
      if (m_mode == 0) begin
         if (m_dwell == SD - 1) begin
            m_dwell = 0;
            if (zeros(m_rs) == 1) begin
               m_pat = m_rs; m_run = 0; m_mode = 1;
            end else m_col = (m_col + 1) % 4;
         end else m_dwell++;
      end else if (m_mode == 1) begin
         if (m_rs == m_pat) begin
            if (m_run == DC - 1) begin
               do_push = 1;
               code = 4'(zero_row(m_pat) * 4 + m_col);
               m_mode = 2; m_run = 0;
            end else m_run++;
         end else begin
            m_mode = 0; m_col = (m_col + 1) % 4; m_dwell = 0;
         end
      end else begin
         if (m_rs == 4'hF) begin
            if (m_run == DC - 1) begin
               m_mode = 0; m_col = (m_col + 1) % 4; m_dwell = 0; m_run = 0;
            end else m_run++;
         end else m_run = 0;
      end
      if (pop) void'(m_fifo.pop_front());
      if (do_push) begin
         if (m_fifo.size() < FD) m_fifo.push_back(code);
         else drop = 1;
      end
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_rs = m_meta;
      m_meta = row;
   endtask

   task automatic check_lit(input string name, input logic [3:0] act, input logic [3:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [3:0] one;
      logic [3:0] exp_col;
      logic [3:0] exp_code;
      if (check_en) begin
         one = 4'b0001;
         exp_col = ~(one << m_col);
         exp_code = (m_fifo.size() != 0) ? m_fifo[0] : 4'h0;
         check_lit("col", col, exp_col);
         check_lit("key_valid", {3'b0, key_valid}, {3'b0, m_fifo.size() != 0});
         check_lit("key_code", key_code, exp_code);
         check_lit("overflow", {3'b0, overflow}, {3'b0, m_ovf});
      end
   end

   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      @(negedge clk);
   endtask

   // Waits for the start of a fresh dwell on the target column.
   task automatic wait_col(input logic [3:0] target);
      int n = 0;
      while (col == target && n < 64) begin tick(); n++; end
      n = 0;
      while (col != target && n < 64) begin tick(); n++; end
      check_lit("wait_col", col, target);
   endtask

   task automatic press(input logic [3:0] pat, input logic [3:0] target);
      wait_col(target);
      row = pat;
      repeat (14) tick();
      row = 4'hF;
      repeat (14) tick();
   endtask

   task automatic pulse_reset(input int cycles);
      #2 reset = 1'b1;
      model_reset();
      repeat (cycles) tick();
      #2 reset = 1'b0;
   endtask

   initial begin
      logic [3:0] seq [4];
      logic [3:0] exp_drain [4];
      seq = '{4'hE, 4'hD, 4'hB, 4'h7};
      exp_drain = '{4'h5, 4'hA, 4'hF, 4'h8};
      model_reset();
      repeat (2) tick();
      #2 reset = 1'b0;

      // Idle scan: four cycles per column, E D B 7 E.
      for (int i = 0; i < 17; i++) begin
         check_lit("idle_col", col, seq[(i / 4) % 4]);
         if (i < 16) tick();
      end
      check_lit("idle_valid", {3'b0, key_valid}, 4'h0);

      // Single press on row 1, column 2.
      wait_col(4'hB);
      row = 4'hD;
      repeat (14) tick();
      check_lit("press_valid", {3'b0, key_valid}, 4'h1);
      check_lit("press_code", key_code, 4'h6);
      check_lit("press_col_held", col, 4'hB);
      row = 4'hF;
      repeat (14) tick();
      key_ready = 1'b1; tick(); key_ready = 1'b0;
      check_lit("press_drained", {3'b0, key_valid}, 4'h0);

      // Bounce during debounce: no push, scanning moves to column 3.
      wait_col(4'hB);
      row = 4'hD; repeat (3) tick();
      row = 4'hF; repeat (3) tick();
      check_lit("bounce_col", col, 4'h7);
      row = 4'hD; repeat (3) tick();
      row = 4'hF; repeat (20) tick();
      check_lit("bounce_valid", {3'b0, key_valid}, 4'h0);

      // Two rows low is a ghost pattern.
      wait_col(4'hB);
      row = 4'hC; repeat (20) tick();
      row = 4'hF; repeat (4) tick();
      check_lit("ghost_valid", {3'b0, key_valid}, 4'h0);

      // Overflow: five presses with the consumer stalled.
      press(4'hE, 4'hE);
      press(4'hD, 4'hD);
      press(4'hB, 4'hB);
      press(4'h7, 4'h7);
      press(4'hE, 4'hD);
      check_lit("ovf_set", {3'b0, overflow}, 4'h1);
      check_lit("ovf_head", key_code, 4'h0);
      overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
      check_lit("ovf_clr", {3'b0, overflow}, 4'h0);

      // Push and pop in the same cycle while full.
      wait_col(4'hE);
      row = 4'hB;
      for (int i = 0; i < 14; i++) begin
         key_ready = (m_mode == 1 && m_run == DC - 1);
         tick();
      end
      key_ready = 1'b0;
      row = 4'hF;
      repeat (14) tick();
      check_lit("full_pp_ovf", {3'b0, overflow}, 4'h0);
      for (int i = 0; i < 4; i++) begin
         check_lit("drain_code", key_code, exp_drain[i]);
         key_ready = 1'b1; tick();
      end
      key_ready = 1'b0;
      check_lit("drain_empty", {3'b0, key_valid}, 4'h0);

      // Reset while a key is held.
      wait_col(4'hB);
      row = 4'hD;
      repeat (14) tick();
      row = 4'hF;
      pulse_reset(2);
      check_lit("rst_col", col, 4'hE);
      check_lit("rst_valid", {3'b0, key_valid}, 4'h0);
      repeat (30) tick();
      check_lit("rst_no_code", {3'b0, key_valid}, 4'h0);

      // Randomized traffic.
      for (int it = 0; it < 250; it++) begin
         int sel, hold, rdy_pct;
         logic [3:0] one;
         one = 4'b0001;
         sel = $urandom_range(0, 9);
         if (sel < 4) row = 4'hF;
         else if (sel < 8) row = ~(one << $urandom_range(0, 3));
         else if (sel == 8) row = ~((one << $urandom_range(0, 1)) | 4'b1000);
         else row = 4'($urandom_range(0, 15));
         hold = $urandom_range(1, 30);
         rdy_pct = $urandom_range(0, 100);
         for (int c = 0; c < hold; c++) begin
            key_ready = ($urandom_range(0, 99) < rdy_pct);
            overflow_clr = ($urandom_range(0, 7) == 0);
            tick();
         end
         key_ready = 1'b0;
         overflow_clr = 1'b0;
         if ($urandom_range(0, 39) == 0) pulse_reset(1);
      end

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 1000, gives the clk cycles each column is driven during scanning (minimum 2).
REQ-002 Parameter DEB_CNT, default 50000, gives the consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 Parameter FIFO_DEPTH, default 4, gives the key-code FIFO entries (power of 2).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 Port clk, input, 1 bit: system clock, all state rising-edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port row, input, 4 bits: keypad rows, active-low, asynchronous to clk.
REQ-008 Port col, output, 4 bits: keypad column drive, active-low, one-cold.
REQ-009 Port key_code, output, 4 bits: FIFO head, code = row_idx*4 + col_idx.
REQ-010 Port key_valid, output, 1 bit: FIFO not empty.
REQ-011 Port key_ready, input, 1 bit: consumer accepts head when key_valid && key_ready.
REQ-012 Port overflow, output, 1 bit: sticky flag, a key was dropped because the FIFO was full.
REQ-013 Port overflow_clr, input, 1 bit: synchronous clear of overflow.

Function
REQ-014 row SHALL pass through a 2-flop synchronizer; "rs" below is the synchronized value.
REQ-015 The FSM SHALL have states SCAN, DEBOUNCE and HELD.
REQ-016 In SCAN, col = ~(1<<idx); a dwell counter runs 0..SCAN_DIV-1; idx advances at count SCAN_DIV-1, wrapping 3->0.
REQ-017 SCAN samples rs only on dwell count SCAN_DIV-1.
REQ-018 SCAN sample rs == 4'hF: advance idx, stay in SCAN.
REQ-019 SCAN sample rs has exactly one 0 bit: latch the pattern, hold idx and col, clear the debounce counter, go to DEBOUNCE.
REQ-020 SCAN sample rs has two or more 0 bits (ghost or multi-key): treat as no key and advance idx.
REQ-021 In DEBOUNCE, each cycle with rs == latched pattern increments the debounce counter; any mismatch returns to SCAN with idx+1, dwell 0, and no push.
REQ-022 When the debounce counter reaches DEB_CNT-1 with a match, the block SHALL push the code in that cycle and go to HELD with the counter cleared.
REQ-023 In HELD, col stays on; the counter increments while rs == 4'hF and clears on any cycle with rs != 4'hF.
REQ-024 HELD SHALL exit at count DEB_CNT-1 to SCAN with idx+1 and dwell 0; a held key produces exactly one code (no auto-repeat).
REQ-025 FIFO behaviour:
  - key_valid = not empty; key_code = head entry, 0 when empty.
  - Pop on key_valid && key_ready.
  - A push into an empty FIFO SHALL be visible on key_valid on the next cycle (no bypass).
REQ-026 Push while full with no pop SHALL drop the new code, keep FIFO contents, and set overflow at the next edge.
REQ-027 Push and pop in the same cycle while full SHALL accept both, leaving the count unchanged and raising no overflow.
REQ-028 Push and pop in the same cycle while holding 1 entry SHALL leave 1 entry, the new code.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
REQ-030 overflow_clr SHALL clear overflow; if it coincides with a dropping push, the set wins.
REQ-031 key_ready while empty SHALL be ignored.

Reset
REQ-032 Reset SHALL apply asynchronously with these values: state SCAN, idx 0, col 4'hE, dwell and debounce counters 0, synchronizer flops 4'hF, FIFO empty, key_valid 0, key_code 0, overflow 0.
REQ-033 Reset asserted mid-DEBOUNCE or mid-HELD SHALL discard the partial event; after release, scanning restarts at column 0 with no push.

Verification (SCAN_DIV=4, DEB_CNT=8, FIFO_DEPTH=4)
REQ-034 Idle rows 4'hF: col SHALL cycle E,D,B,7,E with 4 cycles per column, and key_valid stays 0.
REQ-035 Single press: row 4'hD stable while col=4'hB for ≥ 8+3 cycles -> exactly one code 4'h6 (row1, col2), key_valid=1, and col held at B until rows are 4'hF for 8 cycles.
REQ-036 Bounce: row toggles D/F every 3 cycles during DEBOUNCE -> no push, and scanning resumes at col 4'h7.
REQ-037 Two rows low (4'hC) -> no push.
REQ-038 Overflow: key_ready=0, 5 distinct presses -> 4 codes retained in order, overflow=1.
  - overflow_clr pulse -> overflow=0.
  - key_ready=1 while full plus a push in the same cycle -> count stays 4, overflow stays 0.
REQ-039 Reset mid-HELD: reset pulsed during HELD -> col=4'hE, FIFO empty, and no further code is produced by that held key after release.
